bcd_entry_7b: RTL and testbench

Sequential two-digit decimal entry and BCD-to-binary converter, the inverse of the 7-bit binary-to-2-digit display path. It accepts BCD digits one at a time from a keypad or switch front end and echoes them with leading-zero blanking for the 7-segment driver. On `enter` it converts the two digits to a 7-bit binary count over a fixed multi-cycle shift-add sequence and presents the result to the counter/loader logic with a one-cycle valid strobe.

---
 rtl/bcd_entry_7b.sv | 125 ++++++++++++
 tb/tb_bcd_entry_7b.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/bcd_entry_7b.sv
// Two-digit BCD keypad entry with leading-zero blanked echo and a fixed
// three-cycle shift-add conversion of the entry to a 7-bit binary count.
module bcd_entry_7b (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit_in,
  input  logic       digit_stb,
  input  logic       enter,
  input  logic       clear,
  output logic       busy,
  output logic [6:0] cnt_out,
  output logic       cnt_valid,
  output logic       err,
  output logic [3:0] disp_d1,
  output logic [3:0] disp_d0
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ONE,
    S_TWO,
    S_MUL,
    S_ADD
  } state_t;

  state_t     state, state_next;
  logic [3:0] d1, d1_next;
  logic [3:0] d0, d0_next;
  logic [6:0] acc, acc_next;
  logic [6:0] cnt_next;
  logic       valid_next;
  logic       err_next;
  logic       digit_ok;

  assign digit_ok = (digit_in <= 4'd9);

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    d1_next    = d1;
    d0_next    = d0;
    acc_next   = acc;
    cnt_next   = cnt_out;
    valid_next = 1'b0;
    err_next   = 1'b0;

    unique case (state)
      S_IDLE, S_ONE, S_TWO: begin
        // Strobe priority while accepting input: clear, then enter, then digit.
        if (clear) begin
          d1_next    = 4'd0;
          d0_next    = 4'd0;
          state_next = S_IDLE;
        end else if (enter) begin
          if (state == S_IDLE) err_next   = 1'b1;
          else                 state_next = S_MUL;
        end else if (digit_stb) begin
          if (!digit_ok) begin
            err_next = 1'b1;
          end else if (state == S_IDLE) begin
            d1_next    = 4'd0;
            d0_next    = digit_in;
            state_next = S_ONE;
          end else begin
            d1_next    = d0;
            d0_next    = digit_in;
            state_next = S_TWO;
          end
        end
      end
      S_MUL: begin
        acc_next   = {d1, 3'b000} + {2'b00, d1, 1'b0};
        state_next = S_ADD;
      end
      S_ADD: begin
        cnt_next   = acc + {3'b000, d0};
        valid_next = 1'b1;
        d1_next    = 4'd0;
        d0_next    = 4'd0;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      d1        <= 4'd0;
      d0        <= 4'd0;
      acc       <= 7'd0;
      cnt_out   <= 7'd0;
      cnt_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_next;
      d1        <= d1_next;
      d0        <= d0_next;
      acc       <= acc_next;
      cnt_out   <= cnt_next;
      cnt_valid <= valid_next;
      err       <= err_next;
    end
  end

  assign busy = (state == S_MUL) || (state == S_ADD);

  // Blanking follows how many digits were entered, not their values.
  always_comb begin
    disp_d1 = 4'hF;
    disp_d0 = 4'hF;
    unique case (state)
      S_ONE: disp_d0 = d0;
      S_TWO, S_MUL, S_ADD: begin
        disp_d1 = d1;
        disp_d0 = d0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bcd_entry_7b.sv
// Self-checking bench for bcd_entry_7b: directed scenarios followed by random
// strobes, compared every cycle against a digit-list arithmetic model.
module tb_bcd_entry_7b;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] digit_in;
  logic       digit_stb;
  logic       enter;
  logic       clear;
  logic       busy;
  logic [6:0] cnt_out;
  logic       cnt_valid;
  logic       err;
  logic [3:0] disp_d1;
  logic [3:0] disp_d0;

  bcd_entry_7b dut (
    .clk       (clk),
    .reset     (reset),
    .digit_in  (digit_in),
    .digit_stb (digit_stb),
    .enter     (enter),
    .clear     (clear),
    .busy      (busy),
    .cnt_out   (cnt_out),
    .cnt_valid (cnt_valid),
    .err       (err),
    .disp_d1   (disp_d1),
    .disp_d0   (disp_d0)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: entered digits as numbers plus a conversion countdown.
  int m_ndig     = 0;
  int m_tens     = 0;
  int m_ones     = 0;
  int m_conv     = 0;
  int m_pending  = 0;
  int m_cnt      = 0;
  bit m_valid    = 1'b0;
  bit m_err      = 1'b0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit s, input int d, input bit e, input bit c);
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (r) begin
      m_ndig = 0; m_tens = 0; m_ones = 0; m_conv = 0; m_cnt = 0;
    end else if (m_conv > 0) begin
      m_conv--;
      if (m_conv == 0) begin
        m_cnt   = m_pending;
        m_valid = 1'b1;
        m_ndig  = 0; m_tens = 0; m_ones = 0;
      end
    end else if (c) begin
      m_ndig = 0; m_tens = 0; m_ones = 0;
    end else if (e) begin
      if (m_ndig == 0) m_err = 1'b1;
      else begin
        m_pending = m_tens * 10 + m_ones;
        m_conv    = 2;
      end
    end else if (s) begin
      if (d > 9) m_err = 1'b1;
      else begin
        m_tens = (m_ndig == 0) ? 0 : m_ones;
        m_ones = d;
        m_ndig = (m_ndig == 2) ? 2 : m_ndig + 1;
      end
    end
  endtask

  task automatic check_all();
    int ed1, ed0;
    if (m_conv > 0 || m_ndig == 2) begin ed1 = m_tens; ed0 = m_ones; end
    else if (m_ndig == 1)          begin ed1 = 15;     ed0 = m_ones; end
    else                           begin ed1 = 15;     ed0 = 15;     end
    check("busy",      {7'd0, busy},      8'(m_conv > 0));
    check("cnt_out",   {1'b0, cnt_out},   8'(m_cnt));
    check("cnt_valid", {7'd0, cnt_valid}, 8'(m_valid));
    check("err",       {7'd0, err},       8'(m_err));
    check("disp_d1",   {4'd0, disp_d1},   8'(ed1));
    check("disp_d0",   {4'd0, disp_d0},   8'(ed0));
  endtask

  task automatic step(input bit r, input bit s, input logic [3:0] d, input bit e, input bit c);
    reset = r; digit_stb = s; digit_in = d; enter = e; clear = c;
    @(posedge clk);
    #1;
    model_edge(r, s, int'(d), e, c);
    check_all();
  endtask

  task automatic dig(input logic [3:0] d);  step(1'b0, 1'b1, d, 1'b0, 1'b0); endtask
  task automatic ent();                      step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0); endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; digit_stb = 1'b0; digit_in = 4'd0; enter = 1'b0; clear = 1'b0;
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);

    // 4,7 -> 47
    dig(4'd4); dig(4'd7); ent(); idle(3);
    // 9,9 -> 99; single 0 -> 0
    dig(4'd9); dig(4'd9); ent(); idle(3);
    dig(4'd0); ent(); idle(3);
    // calculator shift: 1,2,3 -> 23
    dig(4'd1); dig(4'd2); dig(4'd3); ent(); idle(3);
    // rejected digit, then enter with nothing entered
    dig(4'hC); idle(1); ent(); idle(1);
    // enter and clear together: clear wins
    dig(4'd5); dig(4'd6); step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1); idle(3);
    // strobes during conversion are ignored
    dig(4'd3); dig(4'd8); ent(); dig(4'd7); step(1'b0, 1'b1, 4'hE, 1'b1, 1'b1); idle(2);
    // reset while in ADD aborts the conversion
    dig(4'd2); dig(4'd1); ent(); idle(1); step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0); idle(2);
    // back-to-back entries, next digit right after the valid cycle
    dig(4'd6); ent(); idle(2); dig(4'd5); dig(4'd0); ent(); idle(3);

    for (int i = 0; i < 600; i++) begin
      bit r, s, e, c;
      logic [3:0] d;
      r = ($urandom_range(0, 99) < 1);
      s = ($urandom_range(0, 99) < 45);
      e = ($urandom_range(0, 99) < 12);
      c = ($urandom_range(0, 99) < 5);
      d = 4'($urandom_range(0, 15));
      step(r, s, d, e, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
